// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline stage register.
//   stage_state_t : occupancy of the stage (EMPTY / ONE / TWO entries held)
//   INSTR_W, PC_W, DATA_W : field widths of the default payload
//     {instr, pc4, aluout, writedata}
package pipe_stage_reg_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam int DATA_W  = 32;

  // Default payload width: instr + pc4 + aluout + writedata
  localparam int PAYLOAD_W = INSTR_W + PC_W + 2 * DATA_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk, reset : clock, asynchronous active-high reset
//   inc        : count up by one this cycle (ignored once saturated)
//   clr        : synchronous clear (wins over inc)
//   cnt        : current count, sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline stage register.
//   clk, reset          : clock, asynchronous active-high reset
//   flush               : squash everything held, next cycle the stage is empty
//   in_valid/in_data    : upstream offer
//   in_ready            : registered accept; low only while both entries are full
//   out_valid/out_data  : downstream payload, taken straight from the main register
//   out_ready           : downstream consume
//   stall_cnt           : saturating count of cycles the upstream was blocked
// The main register is kept at zero whenever it is not live so that an
// empty stage presents a nop downstream.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int WIDTH = PAYLOAD_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] stall_cnt
);

  stage_state_t     state, state_nxt;
  logic [WIDTH-1:0] main_q, main_nxt;
  logic [WIDTH-1:0] skid_q, skid_nxt;
  logic             ready_nxt;
  logic             in_fire, out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= EMPTY;
      main_q   <= '0;
      skid_q   <= '0;
      in_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      main_q   <= main_nxt;
      skid_q   <= skid_nxt;
      in_ready <= ready_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (flush) begin
      // flush beats any same-cycle transfer; an accepted input is dropped
      state_nxt = EMPTY;
      main_nxt  = '0;
      skid_nxt  = '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            main_nxt  = in_data;
            state_nxt = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_nxt = in_data;
          end else if (in_fire) begin
            skid_nxt  = in_data;
            state_nxt = TWO;
          end else if (out_fire) begin
            main_nxt  = '0;
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only the drain side can move
          if (out_fire) begin
            main_nxt  = skid_q;
            skid_nxt  = '0;
            state_nxt = ONE;
          end
        end
        default: begin
          state_nxt = EMPTY;
          main_nxt  = '0;
          skid_nxt  = '0;
        end
      endcase
    end
    // registered ready derived from the next state: no out_ready -> in_ready path
    ready_nxt = (state_nxt != TWO);
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (in_valid & ~in_ready),
    .clr   (1'b0),
    .cnt   (stall_cnt)
  );

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 128, giving the payload width (four 32-bit fields: instr, pc4, aluout, writedata).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the stall-counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous squash of all held entries.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the upstream stage offers in_data.
REQ-007 The block SHALL have port in_data, input, WIDTH bits: the upstream payload.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data holds a live entry.
REQ-010 The block SHALL have port out_data, output, WIDTH bits: the downstream payload.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the downstream stage consumes out_data.
REQ-012 The block SHALL have port stall_cnt, output, CNT_W bits: a saturating count of upstream-blocked cycles.

Function
REQ-013 The block SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-014 The block SHALL hold a main register and a skid register, tracked by a state machine with states EMPTY, ONE and TWO.
REQ-015 The block SHALL drive out_valid = (state != EMPTY) and out_data = main register, with no combinational path from in_* to out_*.
REQ-016 The block SHALL register in_ready, driving it 1 in states EMPTY and ONE and 0 in state TWO, with no combinational path from out_ready to in_ready.
REQ-017 In EMPTY, the block SHALL load main on in_fire and go to ONE; otherwise it SHALL stay in EMPTY.
REQ-018 In ONE, the block SHALL behave as follows:
- in_fire & out_fire: load main with in_data and stay in ONE.
- in_fire only: load skid and go to TWO.
- out_fire only: clear main to 0 and go to EMPTY.
- neither: hold.
REQ-019 In TWO, on out_fire the block SHALL move skid to main, clear skid to 0 and go to ONE; otherwise it SHALL hold.
REQ-020 Latency SHALL be 1 cycle from in_fire to out_valid when the block is EMPTY; full throughput (1 entry per cycle) SHALL hold while out_ready=1.
REQ-021 The block SHALL keep main at 0 whenever out_valid=0, so an empty stage presents a nop (all-zero) instruction.
REQ-022 The block SHALL deliver entries in order with no loss and no duplication; once presented, out_data SHALL remain stable until out_fire.
REQ-023 On flush=1, the block SHALL go to EMPTY next cycle and clear main and skid to 0.
REQ-024 Flush SHALL take priority over simultaneous in_fire and out_fire; an in_fire in the flush cycle SHALL be discarded.
REQ-025 The block SHALL increment stall_cnt by 1 in each cycle with in_valid=1 and in_ready=0, saturating at 2^CNT_W-1 with no wrap.
REQ-026 The block SHALL leave stall_cnt unaffected by flush.

Reset
REQ-027 While reset=1, the block SHALL asynchronously force state=EMPTY, main=0, skid=0, in_ready=0, out_valid=0, out_data=0 and stall_cnt=0.
REQ-028 The block SHALL raise in_ready to 1 on the first clk edge after reset deasserts.
REQ-029 Reset asserted mid-transfer SHALL discard all held entries, with no partial state surviving.

Structure
REQ-030 The shared package SHALL contain the state typedef (EMPTY/ONE/TWO) and the field-width constants (INSTR_W=32, PC_W=32, DATA_W=32).
REQ-031 The stall counter SHALL be a separate sub-module, sat_counter, parameterised by CNT_W, with inputs inc and clr.
REQ-032 The design SHALL contain no other sub-modules and no latches.

Verification
REQ-033 Streaming: out_ready=1; feed 0x1,0x2,0x3 on consecutive cycles -> out_data shows 0x1,0x2,0x3 on the next three cycles, stall_cnt=0.
REQ-034 Backpressure: out_ready=0; offer 0xA then 0xB -> in_ready falls after 0xB, stall_cnt increments each blocked cycle; raise out_ready -> 0xA then 0xB, in order.
REQ-035 Flush: state TWO holding 0xA,0xB; flush=1 together with in_valid=1 (0xC) -> next cycle out_valid=0, out_data=0, and 0xC is never output.
REQ-036 Saturation: CNT_W=4; hold in_valid=1 and out_ready=0 for 20 cycles -> stall_cnt stops at 15.
REQ-037 Reset mid-operation: state TWO; pulse reset between clock edges -> outputs zero immediately; after release, in_ready=1 on the first edge and no old entry appears.
REQ-038 Random: random in_valid/out_ready/flush -> the output sequence equals the scoreboard model and out_data is stable while out_valid & !out_ready.
